// File: rtl/tt_um_carryskip_acc16.sv
// tt_um_carryskip_acc16: byte-streamed 16-bit add/subtract accumulator built on carry-skip slices.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - asynchronous active-low reset
//   ena     - tile enable; low freezes the FSM and all registers
//   ui_in   - operand byte (low byte first, then high byte)
//   uio_in  - [0] in_valid, [1] op (0 add, 1 subtract, sampled with low byte),
//             [2] clr, [3] rd_sel (0 low byte, 1 high byte), [7:4] unused
//   uo_out  - accumulator byte selected by rd_sel
//   uio_out - [4] in_ready, [5] res_valid, [6] carry, [7] ovf, [3:0] zero
//   uio_oe  - constant 8'hF0 (upper nibble of uio is output)
//
// Optional feature: define CSA_SATURATE_EN to clamp the accumulator to
// 16'h7FFF / 16'h8000 on signed overflow instead of wrapping.
module tt_um_carryskip_acc16 #(
    parameter int WIDTH    = 16,
    parameter int SKIP_BLK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NB = 8 / SKIP_BLK;

    typedef enum logic [1:0] {IDLE, LO_HELD, ADD_LO, ADD_HI} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             c8_q, c8_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             res_valid_q, res_valid_d;

    logic in_valid, op_in, clr, rd_sel;
    logic in_ready, xfer, hi;
    logic unused_ok;

    assign in_valid  = uio_in[0];
    assign op_in     = uio_in[1];
    assign clr       = uio_in[2];
    assign rd_sel    = uio_in[3];
    assign unused_ok = &{1'b0, uio_in[7:4]};

    assign in_ready = ena & rst_n & (state_q == IDLE || state_q == LO_HELD);
    assign xfer     = in_valid & in_ready;
    assign hi       = (state_q == ADD_HI);

    // One 8-bit carry-skip adder shared by both byte cycles; operands and
    // carry-in are steered by the current ADD_* state.
    logic [7:0] add_a, add_b, add_s;
    logic       add_ci, add_co, add_c7;
    logic       c, cb, pb, p;

    assign add_a  = hi ? acc_q[15:8] : acc_q[7:0];
    assign add_b  = op_q ? ~(hi ? b_q[15:8] : b_q[7:0]) : (hi ? b_q[15:8] : b_q[7:0]);
    assign add_ci = hi ? c8_q : op_q;

    // Each SKIP_BLK block ripples internally; when every bit propagates,
    // the block carry-in is forwarded directly as its carry-out.
    // add_c7 is the carry into bit 7, i.e. c15 during ADD_HI.
    always_comb begin
        add_s  = '0;
        add_c7 = 1'b0;
        c      = add_ci;
        cb     = 1'b0;
        pb     = 1'b0;
        p      = 1'b0;
        for (int g = 0; g < NB; g++) begin
            cb = c;
            pb = 1'b1;
            for (int i = 0; i < SKIP_BLK; i++) begin
                p                    = add_a[g*SKIP_BLK+i] ^ add_b[g*SKIP_BLK+i];
                add_s[g*SKIP_BLK+i]  = p ^ c;
                add_c7               = (g*SKIP_BLK+i == 7) ? c : add_c7;
                c                    = (add_a[g*SKIP_BLK+i] & add_b[g*SKIP_BLK+i]) | (p & c);
                pb                   = pb & p;
            end
            c = pb ? cb : c;
        end
        add_co = c;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        b_d         = b_q;
        op_d        = op_q;
        c8_d        = c8_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        acc_d       = '0;
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                        res_valid_d = 1'b0;
                    end else if (xfer) begin
                        b_d[7:0]    = ui_in;
                        op_d        = op_in;
                        res_valid_d = 1'b0;
                        state_d     = LO_HELD;
                    end
                end
                LO_HELD: begin
                    if (clr) begin
                        state_d = IDLE;
                    end else if (xfer) begin
                        b_d[15:8] = ui_in;
                        state_d   = ADD_LO;
                    end
                end
                ADD_LO: begin
                    acc_d[7:0] = add_s;
                    c8_d       = add_co;
                    state_d    = ADD_HI;
                end
                ADD_HI: begin
                    acc_d[15:8] = add_s;
                    carry_d     = add_co;
                    ovf_d       = add_c7 ^ add_co;
                    res_valid_d = 1'b1;
`ifdef CSA_SATURATE_EN
                    // acc_q[15] is still the pre-operation sign here.
                    if (add_c7 ^ add_co)
                        acc_d = acc_q[15] ? 16'h8000 : 16'h7FFF;
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            c8_q        <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            op_q        <= op_d;
            c8_q        <= c8_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign uo_out  = rd_sel ? acc_q[15:8] : acc_q[7:0];
    assign uio_out = {ovf_q, carry_q, res_valid_q, in_ready, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_carryskip_acc16.sv
// tb_tt_um_carryskip_acc16: vector table, corner sequences and random ops against an arithmetic model.
module tb_tt_um_carryskip_acc16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic       in_valid = 1'b0, op = 1'b0, clr = 1'b0, rd_sel = 1'b0;
    logic [7:0] uio_in, uo_out, uio_out, uio_oe;

    assign uio_in = {4'b0000, rd_sel, clr, op, in_valid};

    tt_um_carryskip_acc16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

`ifdef CSA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_acc;
    logic        m_c, m_v;

    typedef struct {
        bit          do_clr;
        bit          o;
        logic [15:0] b;
        logic [15:0] acc;
        bit          c;
        bit          v;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Plain signed/unsigned arithmetic reference for one accumulate step.
    function automatic void model(input bit o, input logic [15:0] b);
        int ua, ub, sa, sb, s, r;
        ua = int'(m_acc);
        ub = int'(b);
        sa = $signed(m_acc);
        sb = $signed(b);
        s = o ? sa - sb : sa + sb;
        r = o ? ua - ub : ua + ub;
        m_c = o ? (ua >= ub) : (r > 65535);
        m_v = (s > 32767) || (s < -32768);
        m_acc = r[15:0];
        if (SAT && m_v) m_acc = (s > 0) ? 16'h7FFF : 16'h8000;
    endfunction

    task automatic send(input logic [7:0] d, input bit o);
        int n;
        n = 0;
        while (!uio_out[4] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stayed %b, required 1", uio_out[4]);
        end
        ui_in = d;
        op = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic read_acc(output logic [15:0] v);
        rd_sel = 1'b0;
        #1 v[7:0] = uo_out;
        rd_sel = 1'b1;
        #1 v[15:8] = uo_out;
        rd_sel = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    // Sends both bytes and checks the exact two-edge result latency.
    task automatic run_op(input bit o, input logic [15:0] b, output logic [15:0] acc);
        send(b[7:0], o);
        send(b[15:8], o);
        @(posedge clk);
        #1 chk("res_valid_early", {15'd0, uio_out[5]}, 16'd0);
        @(posedge clk);
        #1 chk("res_valid", {15'd0, uio_out[5]}, 16'd1);
        read_acc(acc);
    endtask

    logic [15:0] got, a0;
    logic [15:0] rb;
    bit          ro;

    initial begin
        tv[0] = '{1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 16'hEDCC, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 16'h0001, 16'h0100, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b0, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        tv[7] = '{1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0};
        tv[8] = '{1'b0, 1'b1, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};

        #3;
        rd_sel = 1'b0;
        #1 chk("rst_uo_lo", {8'h00, uo_out}, 16'h0000);
        rd_sel = 1'b1;
        #1 chk("rst_uo_hi", {8'h00, uo_out}, 16'h0000);
        chk("rst_uio_out", {8'h00, uio_out}, 16'h0000);
        chk("rst_uio_oe", {8'h00, uio_oe}, 16'h00F0);
        rd_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_ready", {15'd0, uio_out[4]}, 16'd1);

        for (int i = 0; i < 9; i++) begin
            if (tv[i].do_clr) begin
                do_clr();
                chk("clr_res_valid", {15'd0, uio_out[5]}, 16'd0);
            end
            run_op(tv[i].o, tv[i].b, got);
            chk($sformatf("vec%0d_acc", i), got, tv[i].acc);
            chk($sformatf("vec%0d_carry", i), {15'd0, uio_out[6]}, {15'd0, tv[i].c});
            chk($sformatf("vec%0d_ovf", i), {15'd0, uio_out[7]}, {15'd0, tv[i].v});
        end

        // Random accumulate stream against the arithmetic model.
        do_clr();
        m_acc = 16'h0000;
        m_c = 1'b0;
        m_v = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_clr();
                m_acc = 16'h0000;
                chk("rnd_clr_carry", {15'd0, uio_out[6]}, 16'd0);
                chk("rnd_clr_ovf", {15'd0, uio_out[7]}, 16'd0);
            end
            ro = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0: rb = 16'h7FFF;
                1: rb = 16'h8000;
                2: rb = 16'hFFFF;
                3: rb = 16'h0001;
                default: rb = 16'($urandom);
            endcase
            model(ro, rb);
            run_op(ro, rb, got);
            chk("rnd_acc", got, m_acc);
            chk("rnd_carry", {15'd0, uio_out[6]}, {15'd0, m_c});
            chk("rnd_ovf", {15'd0, uio_out[7]}, {15'd0, m_v});
        end

        // clr while a low byte is held: low byte discarded, acc untouched.
        read_acc(a0);
        send(8'h55, 1'b0);
        do_clr();
        read_acc(got);
        chk("lo_held_clr_acc", got, a0);
        chk("lo_held_clr_ready", {15'd0, uio_out[4]}, 16'd1);
        model(1'b0, 16'h0102);
        run_op(1'b0, 16'h0102, got);
        chk("after_lo_clr_acc", got, m_acc);

        // ena low mid-stream: no transfer despite in_valid held high.
        read_acc(a0);
        send(8'h11, 1'b0);
        ena = 1'b0;
        #1 chk("ena_low_ready", {15'd0, uio_out[4]}, 16'd0);
        ui_in = 8'hAA;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("ena_low_res_valid", {15'd0, uio_out[5]}, 16'd0);
        read_acc(got);
        chk("ena_low_acc", got, a0);
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model(1'b0, 16'hAA11);
        repeat (2) @(posedge clk);
        #1 chk("ena_resume_res_valid", {15'd0, uio_out[5]}, 16'd1);
        read_acc(got);
        chk("ena_resume_acc", got, m_acc);

        // Reset pulsed while in ADD_LO.
        send(8'h21, 1'b0);
        send(8'h43, 1'b0);
        rst_n = 1'b0;
        rd_sel = 1'b0;
        #1 chk("midrst_uo_lo", {8'h00, uo_out}, 16'h0000);
        rd_sel = 1'b1;
        #1 chk("midrst_uo_hi", {8'h00, uo_out}, 16'h0000);
        chk("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
        chk("midrst_uio_oe", {8'h00, uio_oe}, 16'h00F0);
        rd_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 16'h0000;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_res_valid", {15'd0, uio_out[5]}, 16'd0);
        read_acc(got);
        chk("post_rst_acc", got, 16'h0000);
        model(1'b0, 16'h00F0);
        run_op(1'b0, 16'h00F0, got);
        chk("post_rst_op", got, m_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
